// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants for the sram-like arbiter: owner tags and request sizes.
package sram_like_arbiter_pkg;

  // Owner tag stored per accepted request
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  // sram-like request sizes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // The requester that is not `tag`
  function automatic logic other_tag(input logic tag);
    return ~tag;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_tag_fifo.sv
// In-order 1-bit owner-tag queue. Full ignores a same-cycle pop so that
// mem_req never depends combinationally on mem_data_ok.
module sram_like_arbiter_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = tag_mem[rd_ptr_reg];

  // Tag storage; contents are don't-care while the queue is empty
  always_ff @(posedge clk) begin
    if (do_push) tag_mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the instruction and data
// requesters, holds a stalled selection until accepted, and routes in-order
// responses back to the owner recorded at address acceptance.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING   = 4,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic        inst_cached,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic        data_cached,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        mem_cached,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        protocol_err
);

  logic lock_reg;
  logic lock_sel_reg;
  logic rr_prio_reg;
  logic protocol_err_reg;

  logic sel;
  logic locked_req;
  logic sel_req;
  logic accept;
  logic queue_full;
  logic queue_empty;
  logic head_tag;
  logic resp_valid;

  // Pick the requester: a held selection wins while its owner still asks
  always_comb begin
    locked_req = (lock_sel_reg == TAG_DATA) ? data_req : inst_req;
    if (lock_reg && locked_req) begin
      sel = lock_sel_reg;
    end else if (inst_req && data_req) begin
      sel = DATA_PRIORITY ? TAG_DATA : rr_prio_reg;
    end else begin
      sel = data_req ? TAG_DATA : TAG_INST;
    end
  end

  assign sel_req      = (sel == TAG_DATA) ? data_req : inst_req;
  assign mem_req      = resetn & sel_req & ~queue_full;
  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (sel == TAG_INST);
  assign data_addr_ok = accept & (sel == TAG_DATA);

  assign mem_wr     = (sel == TAG_DATA) ? data_wr     : inst_wr;
  assign mem_cached = (sel == TAG_DATA) ? data_cached : inst_cached;
  assign mem_size   = (sel == TAG_DATA) ? data_size   : inst_size;
  assign mem_wstrb  = (sel == TAG_DATA) ? data_wstrb  : inst_wstrb;
  assign mem_addr   = (sel == TAG_DATA) ? data_addr   : inst_addr;
  assign mem_wdata  = (sel == TAG_DATA) ? data_wdata  : inst_wdata;

  // A response is only routed when there is an owner to route it to
  assign resp_valid   = resetn & mem_data_ok & ~queue_empty;
  assign inst_data_ok = resp_valid & (head_tag == TAG_INST);
  assign data_data_ok = resp_valid & (head_tag == TAG_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign protocol_err = protocol_err_reg;

  sram_like_arbiter_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (mem_data_ok),
    .din    (sel),
    .head   (head_tag),
    .full   (queue_full),
    .empty  (queue_empty)
  );

  // Lock, round-robin pointer and sticky error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_reg         <= 1'b0;
      lock_sel_reg     <= TAG_INST;
      rr_prio_reg      <= TAG_DATA;
      protocol_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        lock_reg    <= 1'b0;
        rr_prio_reg <= other_tag(sel);
      end else if (mem_req) begin
        lock_reg     <= 1'b1;
        lock_sel_reg <= sel;
      end else if (lock_reg && !locked_req) begin
        lock_reg <= 1'b0;
      end
      if (mem_data_ok && queue_empty) protocol_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a queue-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_cached;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr, data_cached;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr, mem_cached;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        protocol_err;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .OUTSTANDING   (4),
    .DATA_PRIORITY (1'b1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_cached  (inst_cached),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_cached  (data_cached),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_cached   (mem_cached),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .protocol_err (protocol_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owners of outstanding requests, held requester
  bit tagq[$];
  bit m_perr = 1'b0;
  int m_held = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester the rules say must own the port this cycle (1 = data)
  function automatic int model_sel();
    if (m_held >= 0 && ((m_held == 1) ? data_req : inst_req)) return m_held;
    if (data_req) return 1;
    return 0;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    int   s;
    logic e_mreq, e_acc, e_iok, e_dok;
    if (!resetn) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_protocol_err", protocol_err, 0);
    end else begin
      s      = model_sel();
      e_mreq = ((s == 1) ? data_req : inst_req) && (tagq.size() < 4);
      e_acc  = e_mreq && mem_addr_ok;
      e_iok  = mem_data_ok && (tagq.size() > 0) && (tagq[0] == 1'b0);
      e_dok  = mem_data_ok && (tagq.size() > 0) && (tagq[0] == 1'b1);
      chk("mem_req", mem_req, e_mreq);
      chk("inst_addr_ok", inst_addr_ok, e_acc && (s == 0));
      chk("data_addr_ok", data_addr_ok, e_acc && (s == 1));
      chk("inst_data_ok", inst_data_ok, e_iok);
      chk("data_data_ok", data_data_ok, e_dok);
      chk("protocol_err", protocol_err, m_perr);
      chk("inst_rdata", inst_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      if (e_mreq) begin
        chk("mem_addr", mem_addr, (s == 1) ? data_addr : inst_addr);
        chk("mem_wdata", mem_wdata, (s == 1) ? data_wdata : inst_wdata);
        chk("mem_ctrl", {mem_wr, mem_cached, mem_size, mem_wstrb},
            (s == 1) ? {data_wr, data_cached, data_size, data_wstrb}
                     : {inst_wr, inst_cached, inst_size, inst_wstrb});
      end
    end
  end

  // Advance the model on each clock edge
  always @(posedge clk) begin : model
    int s;
    bit mreq, acc;
    if (!resetn) begin
      tagq.delete();
      m_perr = 1'b0;
      m_held = -1;
    end else begin
      s    = model_sel();
      mreq = ((s == 1) ? data_req : inst_req) && (tagq.size() < 4);
      acc  = mreq && mem_addr_ok;
      if (mem_data_ok) begin
        if (tagq.size() > 0) void'(tagq.pop_front());
        else m_perr = 1'b1;
      end
      if (acc) tagq.push_back(s == 1);
      if (acc) m_held = -1;
      else if (mreq) m_held = s;
      else if (m_held >= 0 && !((m_held == 1) ? data_req : inst_req)) m_held = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn      = 1'b0;
    inst_req    = 1'b1;
    inst_wr     = 1'b0;
    inst_cached = 1'b1;
    inst_size   = SIZE_WORD;
    inst_wstrb  = 4'hF;
    inst_addr   = 32'hBFC0_0000;
    inst_wdata  = 32'h1111_1111;
    data_req    = 1'b0;
    data_wr     = 1'b1;
    data_cached = 1'b0;
    data_size   = SIZE_HALF;
    data_wstrb  = 4'h3;
    data_addr   = 32'h8000_1000;
    data_wdata  = 32'h2222_2222;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;

    // Reset holds every handshake low even with a live request
    @(negedge clk);
    chk("lit_reset_mem_req", mem_req, 0);
    chk("lit_reset_inst_addr_ok", inst_addr_ok, 0);
    tick();
    resetn   = 1'b1;
    inst_req = 1'b0;
    tick();

    // Inst only: zero-latency grant, response two cycles later
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_t1_inst_addr_ok", inst_addr_ok, 1);
    chk("lit_t1_mem_addr", mem_addr, 32'hBFC0_0000);
    tick();
    inst_req = 1'b0;
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h3C08_0001;
    @(negedge clk);
    chk("lit_t1_inst_data_ok", inst_data_ok, 1);
    chk("lit_t1_inst_rdata", inst_rdata, 32'h3C08_0001);
    chk("lit_t1_data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;

    // Conflict: data first, then inst; responses in the same order
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_addr = 32'h8000_0010;
    @(negedge clk);
    chk("lit_t2_data_addr_ok", data_addr_ok, 1);
    chk("lit_t2_inst_addr_ok", inst_addr_ok, 0);
    chk("lit_t2_mem_addr", mem_addr, 32'h8000_0010);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("lit_t2_inst_addr_ok2", inst_addr_ok, 1);
    chk("lit_t2_mem_addr2", mem_addr, 32'hBFC0_0004);
    tick();
    inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
    @(negedge clk);
    chk("lit_t2_first_data_ok", data_data_ok, 1);
    chk("lit_t2_first_inst_ok", inst_data_ok, 0);
    tick();
    mem_rdata = 32'h0000_0022;
    @(negedge clk);
    chk("lit_t2_second_inst_ok", inst_data_ok, 1);
    chk("lit_t2_second_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;

    // Lock: stalled inst keeps the port despite a higher-priority data req
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("lit_t3_c1_mem_addr", mem_addr, 32'hBFC0_0100);
    tick();
    data_req = 1'b1; data_addr = 32'h8000_0200;
    @(negedge clk);
    chk("lit_t3_c2_mem_addr", mem_addr, 32'hBFC0_0100);
    chk("lit_t3_c2_data_addr_ok", data_addr_ok, 0);
    tick();
    @(negedge clk);
    chk("lit_t3_c3_mem_addr", mem_addr, 32'hBFC0_0100);
    tick();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_t3_c4_inst_addr_ok", inst_addr_ok, 1);
    chk("lit_t3_c4_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("lit_t3_c5_data_addr_ok", data_addr_ok, 1);
    chk("lit_t3_c5_mem_addr", mem_addr, 32'h8000_0200);
    tick();
    data_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0033;
    @(negedge clk);
    chk("lit_t3_resp1_inst", inst_data_ok, 1);
    tick();
    @(negedge clk);
    chk("lit_t3_resp2_data", data_data_ok, 1);
    tick();
    mem_data_ok = 1'b0;

    // Retract: locked inst drops, data is granted in the same cycle
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300; mem_addr_ok = 1'b0;
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h8000_0300; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_t4_data_addr_ok", data_addr_ok, 1);
    chk("lit_t4_inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("lit_t4_data_data_ok", data_data_ok, 1);
    chk("lit_t4_inst_data_ok", inst_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;

    // Full: four accepted, fifth blocked; a pop frees a slot next cycle
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'hBFC0_1000 + 32'(i * 4);
      tick();
    end
    @(negedge clk);
    chk("lit_t5_full_mem_req", mem_req, 0);
    chk("lit_t5_full_inst_addr_ok", inst_addr_ok, 0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    chk("lit_t5_pop_cycle_mem_req", mem_req, 0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("lit_t5_after_pop_mem_req", mem_req, 1);
    tick();

    // Wrap: alternating owners with simultaneous push and pop
    for (int i = 0; i < 12; i++) begin
      inst_req    = (i % 2 == 0);
      data_req    = (i % 2 == 1);
      inst_addr   = 32'h0000_1000 + 32'(i);
      data_addr   = 32'h0000_2000 + 32'(i);
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0000_00A0 + 32'(i);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0;
    for (int k = 0; k < 8 && tagq.size() > 0; k++) begin
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0000_00C0 + 32'(k);
      tick();
    end
    mem_data_ok = 1'b0;
    chk("drain_bound", tagq.size(), 0);

    // Protocol error: response with nothing outstanding
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("lit_t6_perr_before", protocol_err, 0);
    chk("lit_t6_inst_data_ok", inst_data_ok, 0);
    chk("lit_t6_data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("lit_t6_perr_after", protocol_err, 1);
    tick();

    // Reset mid-transaction with a request outstanding
    data_req = 1'b1; data_addr = 32'h8000_0400;
    tick();
    data_req = 1'b0; inst_req = 1'b1; mem_data_ok = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("lit_t7_rst_mem_req", mem_req, 0);
    chk("lit_t7_rst_inst_addr_ok", inst_addr_ok, 0);
    chk("lit_t7_rst_data_data_ok", data_data_ok, 0);
    chk("lit_t7_rst_perr", protocol_err, 0);
    tick();
    resetn = 1'b1; inst_req = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("lit_t7_empty_data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("lit_t7_empty_perr", protocol_err, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the instruction requester (pre-IF/IF) and the data requester (EX/MEM).
- Picks one requester per address handshake and holds that choice stable until the address is accepted.
- Records the owner of each accepted request in an in-order tag queue, and routes each data_ok and its rdata back to that owner.
- Sits between the CPU core and the cache/AXI bridge.

Parameters:
- OUTSTANDING, 4: maximum accepted-but-unanswered requests; must be a power of 2, at least 2.
- DATA_PRIORITY, 1: 1 means fixed data-over-inst priority; 0 means round-robin.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req / inst_wr / inst_cached  in  1 each  instruction sram-like request fields
- inst_size  in  2  instruction request size
- inst_wstrb  in  4  instruction write strobes
- inst_addr / inst_wdata  in  32 each  instruction address and write data
- inst_addr_ok / inst_data_ok  out  1 each  instruction handshakes
- inst_rdata  out  32  instruction read data
- data_req / data_wr / data_cached / data_size / data_wstrb / data_addr / data_wdata  in  same widths as inst_*  data requester fields
- data_addr_ok / data_data_ok  out  1 each  data handshakes
- data_rdata  out  32  data read data
- mem_req / mem_wr / mem_cached  out  1 each  request to memory side
- mem_size  out  2  request size to memory side
- mem_wstrb  out  4  write strobes to memory side
- mem_addr / mem_wdata  out  32 each  address and write data to memory side
- mem_addr_ok / mem_data_ok  in  1 each  memory-side handshakes
- mem_rdata  in  32  memory-side read data
- protocol_err  out  1  sticky flag: data_ok received while the tag queue was empty

Behaviour:
- Reset (resetn low, asynchronous):
  - tag queue empty, lock cleared, round-robin pointer set to data, protocol_err=0.
  - All *_addr_ok, *_data_ok and mem_req are 0 while reset is asserted.
- Selection (combinational when unlocked):
  - DATA_PRIORITY=1: data wins whenever data_req=1.
  - DATA_PRIORITY=0: on conflict, the requester not granted last wins; the pointer updates only on an accepted handshake.
- Request to memory:
  - mem_req = selected_req & !queue_full.
  - All mem_* request fields mux from the selected requester.
  - queue_full ignores any same-cycle pop. There is no combinational path from mem_data_ok to mem_req.
- Address handshake:
  - sel_addr_ok = mem_req & mem_addr_ok for the selected requester; the other requester's addr_ok stays 0.
  - On acceptance, push tag (0=inst, 1=data). This is zero-latency: the grant happens in the same cycle as the request.
- Lock:
  - If mem_req=1 & mem_addr_ok=0, set lock and hold the selection next cycle, even if the other requester has higher priority.
  - Lock clears on acceptance.
  - Lock also clears if the locked requester drops its req (inst side may retract on exceptions). The other requester may then be granted that same cycle.
- Data return:
  - mem_data_ok pops the head tag.
  - The head tag's data_ok pulses for 1 cycle.
  - mem_rdata is broadcast to both *_rdata; only the tagged requester sees data_ok.
  - Responses are strictly in order.
- Simultaneous push and pop: both are applied and the count is unchanged. When full, the push cannot happen (mem_req=0).
- Empty queue with mem_data_ok=1: no pop, no data_ok, protocol_err<=1. It stays 1 until reset.
- Pointers wrap modulo OUTSTANDING. The count is clog2(OUTSTANDING)+1 bits wide.
- The arbiter does not implement discard: requesters handle their own discard after a retract, using their own data_ok.

Decomposition:
- Shared package/header sram_like.vh:
  - TAG_INST=1'b0, TAG_DATA=1'b1
  - SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2
- Sub-module tag_fifo:
  - 1-bit wide, depth OUTSTANDING.
  - Ports: push, pop, head, full, empty.
  - Async active-low reset.

Test Plan:
- Inst only: inst_req=1, addr 0xBFC00000, mem_addr_ok=1 -> inst_addr_ok=1 same cycle; mem_data_ok 2 cycles later with rdata 0x3C080001 -> inst_data_ok=1, inst_rdata=0x3C080001, data_data_ok=0.
- Conflict with DATA_PRIORITY=1: both req, mem_addr_ok=1 -> data granted, mem_addr=data_addr; next cycle inst granted. Two data_oks -> data_data_ok first, then inst_data_ok.
- Lock hold: inst req with mem_addr_ok=0 for 3 cycles while data_req rises in cycle 2 -> mem_addr stays inst_addr until accepted in cycle 4; data granted in cycle 5.
- Retract: locked inst drops req in cycle 2 while data_req=1 -> data_addr_ok=1 in cycle 2 if mem_addr_ok=1; no inst tag pushed.
- Full and wrap: OUTSTANDING=4, 4 accepted with no data_ok -> mem_req=0 on 5th. One data_ok -> mem_req=1 the next cycle; run 10 requests so pointers wrap 2x, with tag order preserved.
- Error and reset: mem_data_ok with empty queue -> protocol_err=1, no data_ok. Drop resetn mid-transaction -> all outputs 0 immediately, queue empty after release.
